// File: rtl/processor.sv
// Pipelined shift-and-add W x W multiplier; PRCSSR_SIGNED_EN selects two's-complement operands.
// Latency: product of operands sampled at edge k is on m after edge k+W (W+1 register stages).
// Backpressure: none; free-running, accepts one pair every cycle, m_vld marks post-reset results.
module processor #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] m,
    output logic           m_vld
);

`ifdef PRCSSR_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    // Stage 0 is the input register; stages 1..W each fold in one bit of B.
    logic [W-1:0]   a_q   [0:W-1];
    logic [W-1:0]   a_d   [0:W-1];
    logic [W-1:0]   b_q   [0:W-1];
    logic [W-1:0]   b_d   [0:W-1];
    logic [2*W-1:0] p_q   [0:W];
    logic [2*W-1:0] p_d   [0:W];
    logic [2*W-1:0] pp    [1:W];
    logic           vld_q [0:W];
    logic           vld_d [0:W];

    function automatic logic [2*W-1:0] extend(input logic [W-1:0] x);
        if (SIGNED_MODE) begin
            return {{W{x[W-1]}}, x};
        end
        return {{W{1'b0}}, x};
    endfunction

    always_comb begin
        a_d[0]   = a;
        b_d[0]   = b;
        p_d[0]   = '0;
        vld_d[0] = 1'b1;
        for (int i = 1; i < W; i++) begin
            a_d[i] = a_q[i-1];
            b_d[i] = b_q[i-1];
        end
        for (int i = 1; i <= W; i++) begin
            vld_d[i] = vld_q[i-1];
            pp[i]    = extend(a_q[i-1]) << (i - 1);
            p_d[i]   = p_q[i-1];
            if (b_q[i-1][i-1]) begin
                // In two's complement the MSB of B carries negative weight.
                if (SIGNED_MODE && (i == W)) begin
                    p_d[i] = p_q[i-1] - pp[i];
                end else begin
                    p_d[i] = p_q[i-1] + pp[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i <= W; i++) begin
                p_q[i]   <= '0;
                vld_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
            for (int i = 0; i <= W; i++) begin
                p_q[i]   <= p_d[i];
                vld_q[i] <= vld_d[i];
            end
        end
    end

    assign m     = p_q[W] & {(2*W){vld_q[W]}};
    assign m_vld = vld_q[W];

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor (W=4): scoreboard of expected products, immediate assertions.
module tb_processor;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] m;
    logic       m_vld;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

`ifdef PRCSSR_SIGNED_EN
    localparam int ND = 4;
    logic [15:0] dir [ND] = '{16'h8840, 16'h87C8, 16'hFF01, 16'h7731};
`else
    localparam int ND = 8;
    logic [15:0] dir [ND] = '{16'h350F, 16'hFFE1, 16'h0000, 16'h1F0F,
                              16'hF10F, 16'h0900, 16'h1909, 16'h9109};
`endif

    processor #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .m     (m),
        .m_vld (m_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
`ifdef PRCSSR_SIGNED_EN
        logic signed [7:0] r;
        r = $signed(x) * $signed(y);
        return r;
`else
        logic [7:0] r;
        r = {4'h0, x} * {4'h0, y};
        return r;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled at the falling edge; a result is due once 5 entries are queued.
    task automatic check_out(input string tag);
        logic [7:0] exp;
        if (sb.size() == 5) begin
            exp = sb.pop_front();
            chk({tag, "_m"}, m, exp);
            chk({tag, "_vld"}, {7'd0, m_vld}, 8'd1);
        end else begin
            chk({tag, "_m_idle"}, m, 8'h00);
            chk({tag, "_vld_idle"}, {7'd0, m_vld}, 8'd0);
        end
    endtask

    task automatic step_e(input logic [3:0] na, input logic [3:0] nb,
                          input logic [7:0] exp, input string tag);
        a = na;
        b = nb;
        @(posedge clk);
        if (rst_n) sb.push_back(exp);
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic step(input logic [3:0] na, input logic [3:0] nb, input string tag);
        step_e(na, nb, model(na, nb), tag);
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  v;
        rst_n = 1'b0;
        a = 4'hF;
        b = 4'hF;

        // Reset held with maximum operands applied
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m", m, 8'h00);
        chk("rst_vld", {7'd0, m_vld}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(4'hF, 4'hF, "rel");

        // Directed values with literal expectations, back to back
        for (int i = 0; i < ND; i++) begin
            e = dir[i];
            step_e(e[15:12], e[11:8], e[7:0], "dir");
        end

        // Exhaustive sweep of all operand pairs, one per cycle
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            step(v[7:4], v[3:0], "sweep");
        end
        for (int i = 0; i < 4; i++) step(4'h0, 4'h0, "flush");

        // Asynchronous reset between edges with products in flight
        for (int i = 0; i < 3; i++) step(4'hD, 4'hB, "pre");
        #2 rst_n = 1'b0;
        #1;
        chk("async_m", m, 8'h00);
        chk("async_vld", {7'd0, m_vld}, 8'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("inrst_m", m, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(4'h6, 4'h7, "post");
        for (int i = 0; i < ND; i++) begin
            e = dir[i];
            step_e(e[15:12], e[11:8], e[7:0], "dir2");
        end
        for (int i = 0; i < 4; i++) step(4'h0, 4'h0, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
